// File: rtl/config_frame_writer_pkg.sv
// -----------------------------------------------------------------------------
// config_frame_pkg
//
// Shared definitions for the configuration frame writer:
//   - frame_state_e : writer FSM states (IDLE, ROWS, STROBE)
//   - HDR_COL_LSB   : bit position of the column index inside a header word
//   - ROW_NONE      : RowSelect value meaning "no row captures this cycle"
// -----------------------------------------------------------------------------
package config_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROWS   = 2'd1,
        STROBE = 2'd2
    } frame_state_e;

    localparam int HDR_COL_LSB = 32'sd0;
    localparam int ROW_NONE    = 32'sd0;

endpackage : config_frame_pkg

// File: rtl/config_frame_writer.sv
// -----------------------------------------------------------------------------
// config_frame_writer
//
// Producer side of the fabric configuration frame path. Takes a header word
// (column index) followed by NUM_ROWS row words, broadcasts each row word on
// FrameData_O together with its row number on RowSelect_O, then pulses
// FrameStrobe_O with the column on FrameSelect_O. Frames addressed to an
// out-of-range column are consumed silently and raise a sticky HeaderError_O.
//
// Ports:
//   CLK            in   clock
//   RST            in   synchronous active-high reset
//   WordData_I     in   header or row word
//   WordValid_I    in   word valid
//   WordReady_O    out  word accepted when valid & ready (decoded from state)
//   FrameData_O    out  registered row data broadcast
//   RowSelect_O    out  registered row index capturing FrameData_O (0 = none)
//   FrameSelect_O  out  registered target column, valid with the strobe
//   FrameStrobe_O  out  registered one-cycle frame commit pulse
//   Busy_O         out  registered, high while in ROWS or STROBE
//   HeaderError_O  out  sticky out-of-range column flag, cleared by RST only
// -----------------------------------------------------------------------------
module config_frame_writer
    import config_frame_pkg::*;
#(
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int ROW_SELECT_WIDTH   = 5,
    parameter int NUM_ROWS           = 16,
    parameter int FRAME_SELECT_WIDTH = 5,
    parameter int NUM_COLUMNS        = 20
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [FRAME_BITS_PER_ROW-1:0] WordData_I,
    input  logic                          WordValid_I,
    output logic                          WordReady_O,
    output logic [FRAME_BITS_PER_ROW-1:0] FrameData_O,
    output logic [ROW_SELECT_WIDTH-1:0]   RowSelect_O,
    output logic [FRAME_SELECT_WIDTH-1:0] FrameSelect_O,
    output logic                          FrameStrobe_O,
    output logic                          Busy_O,
    output logic                          HeaderError_O
);

    // One extra bit so NUM_COLUMNS == 2^FRAME_SELECT_WIDTH still compares correctly.
    localparam logic [FRAME_SELECT_WIDTH:0] NUM_COLUMNS_W   = (FRAME_SELECT_WIDTH+1)'(NUM_COLUMNS);
    localparam logic [ROW_SELECT_WIDTH-1:0] LAST_ROW_W      = ROW_SELECT_WIDTH'(NUM_ROWS);
    localparam logic [ROW_SELECT_WIDTH-1:0] FIRST_ROW_W     = ROW_SELECT_WIDTH'(32'd1);
    localparam logic [ROW_SELECT_WIDTH-1:0] ROW_NONE_W      = ROW_SELECT_WIDTH'(ROW_NONE);

    frame_state_e                    state_r;
    frame_state_e                    state_nxt_s;
    logic [ROW_SELECT_WIDTH-1:0]     row_cnt_r;
    logic [FRAME_SELECT_WIDTH-1:0]   col_r;
    logic                            discard_r;
    logic [FRAME_BITS_PER_ROW-1:0]   frame_data_r;
    logic [ROW_SELECT_WIDTH-1:0]     row_sel_r;
    logic [FRAME_SELECT_WIDTH-1:0]   frame_sel_r;
    logic                            strobe_r;
    logic                            busy_r;
    logic                            hdr_err_r;

    logic                            ready_s;
    logic                            accept_s;
    logic [FRAME_SELECT_WIDTH-1:0]   hdr_col_s;
    logic                            col_ok_s;
    logic                            last_row_s;

    // Ready is a pure decode of the state register: only the STROBE cycle stalls.
    assign ready_s    = (state_r != STROBE);
    assign accept_s   = WordValid_I & ready_s;
    assign hdr_col_s  = WordData_I[HDR_COL_LSB +: FRAME_SELECT_WIDTH];
    assign col_ok_s   = ({1'b0, hdr_col_s} < NUM_COLUMNS_W);
    assign last_row_s = (row_cnt_r == LAST_ROW_W);

    // Next-state logic for the header / rows / strobe sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ROWS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ROWS: begin
                if (accept_s && last_row_s) begin
                    state_nxt_s = STROBE;
                end else begin
                    state_nxt_s = ROWS;
                end
            end
            STROBE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, row counter, header latch and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            row_cnt_r    <= FIRST_ROW_W;
            col_r        <= '0;
            discard_r    <= 1'b0;
            frame_data_r <= '0;
            row_sel_r    <= ROW_NONE_W;
            frame_sel_r  <= '0;
            strobe_r     <= 1'b0;
            busy_r       <= 1'b0;
            hdr_err_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            // Row select and strobe are single-cycle pulses unless re-asserted below.
            row_sel_r   <= ROW_NONE_W;
            strobe_r    <= 1'b0;
            frame_sel_r <= '0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        col_r     <= hdr_col_s;
                        row_cnt_r <= FIRST_ROW_W;
                        discard_r <= ~col_ok_s;
                        if (!col_ok_s) begin
                            hdr_err_r <= 1'b1;
                        end
                    end
                end
                ROWS: begin
                    if (accept_s) begin
                        frame_data_r <= WordData_I;
                        row_sel_r    <= discard_r ? ROW_NONE_W : row_cnt_r;
                        row_cnt_r    <= row_cnt_r + FIRST_ROW_W;
                    end
                end
                STROBE: begin
                    strobe_r    <= ~discard_r;
                    frame_sel_r <= discard_r ? '0 : col_r;
                end
                default: begin
                end
            endcase
        end
    end

    assign WordReady_O   = ready_s;
    assign FrameData_O   = frame_data_r;
    assign RowSelect_O   = row_sel_r;
    assign FrameSelect_O = frame_sel_r;
    assign FrameStrobe_O = strobe_r;
    assign Busy_O        = busy_r;
    assign HeaderError_O = hdr_err_r;

endmodule : config_frame_writer

// File: tb/tb_config_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_config_frame_writer
//
// Directed self-checking bench for config_frame_writer with default parameters
// (32-bit words, 16 rows, 20 columns). Inputs change 1 ns after each rising
// edge and outputs are sampled at that same point, so every check looks at the
// registers loaded by the edge just passed.
// -----------------------------------------------------------------------------
module tb_config_frame_writer;

    logic        CLK;
    logic        RST;
    logic [31:0] WordData_I;
    logic        WordValid_I;
    logic        WordReady_O;
    logic [31:0] FrameData_O;
    logic [4:0]  RowSelect_O;
    logic [4:0]  FrameSelect_O;
    logic        FrameStrobe_O;
    logic        Busy_O;
    logic        HeaderError_O;

    int checks;
    int errors;

    config_frame_writer dut (
        .CLK           (CLK),
        .RST           (RST),
        .WordData_I    (WordData_I),
        .WordValid_I   (WordValid_I),
        .WordReady_O   (WordReady_O),
        .FrameData_O   (FrameData_O),
        .RowSelect_O   (RowSelect_O),
        .FrameSelect_O (FrameSelect_O),
        .FrameStrobe_O (FrameStrobe_O),
        .Busy_O        (Busy_O),
        .HeaderError_O (HeaderError_O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance past the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; WordValid_I = 1'b0; WordData_I = 32'h0;
        step(); step();
        checks++;
        if (FrameData_O !== 32'h0 || RowSelect_O !== 5'd0 || FrameSelect_O !== 5'd0 ||
            FrameStrobe_O !== 1'b0 || Busy_O !== 1'b0 || HeaderError_O !== 1'b0 || WordReady_O !== 1'b1) begin
            errors++;
            $display("FAIL reset: data=%h row=%0d col=%0d stb=%b busy=%b err=%b rdy=%b required 0/0/0/0/0/0/1",
                     FrameData_O, RowSelect_O, FrameSelect_O, FrameStrobe_O, Busy_O, HeaderError_O, WordReady_O);
        end
        RST = 1'b0;
    endtask

    task automatic test_valid_frame();
        WordValid_I = 1'b1; WordData_I = 32'h0000_0003;
        step();
        checks++;
        if (Busy_O !== 1'b1 || RowSelect_O !== 5'd0) begin
            errors++;
            $display("FAIL frame_hdr: busy=%b row=%0d required busy=1 row=0", Busy_O, RowSelect_O);
        end
        for (int r = 1; r <= 16; r++) begin
            WordData_I = 32'h1000_0000 + r;
            step();
            checks++;
            if (RowSelect_O !== 5'(r) || FrameData_O !== 32'h1000_0000 + r || Busy_O !== 1'b1 ||
                FrameStrobe_O !== 1'b0 || WordReady_O !== (r != 16)) begin
                errors++;
                $display("FAIL frame_row r=%0d: row=%0d data=%h busy=%b stb=%b rdy=%b", r,
                         RowSelect_O, FrameData_O, Busy_O, FrameStrobe_O, WordReady_O);
            end
        end
        WordValid_I = 1'b0;
        step();
        checks++;
        if (FrameStrobe_O !== 1'b1 || FrameSelect_O !== 5'd3 || RowSelect_O !== 5'd0 ||
            Busy_O !== 1'b0 || WordReady_O !== 1'b1) begin
            errors++;
            $display("FAIL frame_strobe: stb=%b col=%0d row=%0d busy=%b rdy=%b required 1/3/0/0/1",
                     FrameStrobe_O, FrameSelect_O, RowSelect_O, Busy_O, WordReady_O);
        end
        step();
        checks++;
        if (FrameStrobe_O !== 1'b0) begin
            errors++;
            $display("FAIL frame_strobe_width: stb=%b required 0", FrameStrobe_O);
        end
    endtask

    task automatic test_throttled();
        WordValid_I = 1'b1; WordData_I = 32'h0000_0007;
        step();
        for (int r = 1; r <= 16; r++) begin
            WordValid_I = 1'b1; WordData_I = 32'h2000_0000 + r;
            step();
            checks++;
            if (RowSelect_O !== 5'(r) || FrameData_O !== 32'h2000_0000 + r) begin
                errors++;
                $display("FAIL throttle_row r=%0d: row=%0d data=%h", r, RowSelect_O, FrameData_O);
            end
            WordValid_I = 1'b0; WordData_I = 32'hDEAD_BEEF;
            step();
            checks++;
            if (RowSelect_O !== 5'd0 || FrameData_O !== 32'h2000_0000 + r || FrameStrobe_O !== (r == 16)) begin
                errors++;
                $display("FAIL throttle_gap r=%0d: row=%0d data=%h stb=%b", r, RowSelect_O, FrameData_O, FrameStrobe_O);
            end
        end
        checks++;
        if (FrameSelect_O !== 5'd7) begin
            errors++;
            $display("FAIL throttle_col: col=%0d required 7", FrameSelect_O);
        end
        step();
    endtask

    task automatic test_header_error();
        // Low five bits = 25; upper bits must be ignored.
        WordValid_I = 1'b1; WordData_I = 32'hABCD_0019;
        step();
        checks++;
        if (HeaderError_O !== 1'b1 || Busy_O !== 1'b1) begin
            errors++;
            $display("FAIL hdr_err_set: err=%b busy=%b required 1/1", HeaderError_O, Busy_O);
        end
        for (int r = 1; r <= 16; r++) begin
            WordData_I = 32'h5000_0000 + r;
            step();
            checks++;
            if (RowSelect_O !== 5'd0 || FrameStrobe_O !== 1'b0) begin
                errors++;
                $display("FAIL hdr_err_row r=%0d: row=%0d stb=%b required 0/0", r, RowSelect_O, FrameStrobe_O);
            end
        end
        WordValid_I = 1'b0;
        step();
        checks++;
        if (FrameStrobe_O !== 1'b0 || HeaderError_O !== 1'b1 || Busy_O !== 1'b0) begin
            errors++;
            $display("FAIL hdr_err_nostrobe: stb=%b err=%b busy=%b required 0/1/0", FrameStrobe_O, HeaderError_O, Busy_O);
        end
        // Column 0 with junk in upper bits.
        WordValid_I = 1'b1; WordData_I = 32'hFFFF_FFE0;
        step();
        for (int r = 1; r <= 16; r++) begin
            WordData_I = 32'h6000_0000 + r;
            step();
            checks++;
            if (RowSelect_O !== 5'(r) || FrameData_O !== 32'h6000_0000 + r) begin
                errors++;
                $display("FAIL col0_row r=%0d: row=%0d data=%h", r, RowSelect_O, FrameData_O);
            end
        end
        WordValid_I = 1'b0;
        step();
        checks++;
        if (FrameStrobe_O !== 1'b1 || FrameSelect_O !== 5'd0 || HeaderError_O !== 1'b1) begin
            errors++;
            $display("FAIL col0_strobe: stb=%b col=%0d err=%b required 1/0/1", FrameStrobe_O, FrameSelect_O, HeaderError_O);
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        WordValid_I = 1'b1; WordData_I = 32'h0000_0009;
        step();
        for (int r = 1; r <= 7; r++) begin
            WordData_I = 32'h7000_0000 + r;
            step();
            checks++;
            if (RowSelect_O !== 5'(r)) begin
                errors++;
                $display("FAIL midrst_row r=%0d: row=%0d", r, RowSelect_O);
            end
        end
        // Row 8 presented together with reset must be dropped.
        RST = 1'b1; WordData_I = 32'h7000_0008;
        step();
        checks++;
        if (FrameData_O !== 32'h0 || RowSelect_O !== 5'd0 || FrameStrobe_O !== 1'b0 || FrameSelect_O !== 5'd0 ||
            Busy_O !== 1'b0 || HeaderError_O !== 1'b0 || WordReady_O !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clear: data=%h row=%0d stb=%b col=%0d busy=%b err=%b rdy=%b",
                     FrameData_O, RowSelect_O, FrameStrobe_O, FrameSelect_O, Busy_O, HeaderError_O, WordReady_O);
        end
        RST = 1'b0; WordData_I = 32'h0000_0005;
        step();
        checks++;
        if (Busy_O !== 1'b1 || RowSelect_O !== 5'd0) begin
            errors++;
            $display("FAIL midrst_hdr: busy=%b row=%0d required 1/0", Busy_O, RowSelect_O);
        end
        for (int r = 1; r <= 16; r++) begin
            WordData_I = 32'h8000_0000 + r;
            step();
            checks++;
            if (RowSelect_O !== 5'(r) || FrameData_O !== 32'h8000_0000 + r) begin
                errors++;
                $display("FAIL midrst_row2 r=%0d: row=%0d data=%h", r, RowSelect_O, FrameData_O);
            end
        end
        WordValid_I = 1'b0;
        step();
        checks++;
        if (FrameStrobe_O !== 1'b1 || FrameSelect_O !== 5'd5) begin
            errors++;
            $display("FAIL midrst_strobe: stb=%b col=%0d required 1/5", FrameStrobe_O, FrameSelect_O);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_row;
        logic [31:0] exp_data;
        logic        exp_rdy;
        logic        exp_stb;
        logic [4:0]  exp_col;
        WordValid_I = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            if (c == 1)                 WordData_I = 32'h0000_000B;
            else if (c <= 17)           WordData_I = 32'h3000_0000 + (c - 1);
            else if (c == 19)           WordData_I = 32'h0000_000C;
            else if (c >= 20 && c <= 35) WordData_I = 32'h4000_0000 + (c - 19);
            else                        WordData_I = 32'hDEAD_BEEF;
            step();
            exp_rdy = !(c == 17 || c == 35);
            exp_stb = (c == 18 || c == 36);
            exp_col = (c == 18) ? 5'd11 : ((c == 36) ? 5'd12 : 5'd0);
            exp_row = 5'd0;
            exp_data = 32'h0;
            if (c >= 2 && c <= 17) begin
                exp_row = 5'(c - 1); exp_data = 32'h3000_0000 + (c - 1);
            end else if (c >= 20 && c <= 35) begin
                exp_row = 5'(c - 19); exp_data = 32'h4000_0000 + (c - 19);
            end
            checks++;
            if (WordReady_O !== exp_rdy || FrameStrobe_O !== exp_stb || FrameSelect_O !== exp_col ||
                RowSelect_O !== exp_row || (exp_row != 5'd0 && FrameData_O !== exp_data)) begin
                errors++;
                $display("FAIL b2b c=%0d: rdy=%b/%b stb=%b/%b col=%0d/%0d row=%0d/%0d data=%h/%h (got/required)",
                         c, WordReady_O, exp_rdy, FrameStrobe_O, exp_stb, FrameSelect_O, exp_col,
                         RowSelect_O, exp_row, FrameData_O, exp_data);
            end
        end
        WordValid_I = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        WordValid_I = 1'b0;
        WordData_I = 32'h0;
        test_reset();
        test_valid_frame();
        test_throttled();
        test_header_error();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_config_frame_writer
